// File: rtl/ring_pkg.sv
// Shared types and helpers for the token-ring scheduler: FSM state encoding,
// width helpers and a saturating increment used by every bounded counter.
package ring_pkg;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        HOLD    = 2'd1,
        TRANSIT = 2'd2,
        LOST    = 2'd3
    } ring_state_t;

    // Width of a node index; a degenerate single-node ring still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    // Counters stick at their limit instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
        return (val >= lim) ? lim : val + 32'd1;
    endfunction

endpackage

// File: rtl/ring_loss_timer.sv
// Token-loss recovery: LOST dwell timer, consecutive-loss counter, sticky fault and regen pulse.
// expire is combinational from the registered timer; regen/fault are registered; no backpressure.
module ring_loss_timer
    import ring_pkg::*;
#(
    parameter int TIMEOUT  = 5,
    parameter int MAX_LOSS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    input  logic lap_done,
    output logic expire,
    output logic regen,
    output logic fault
);

    localparam int TMW = cnt_width(TIMEOUT);
    localparam int LCW = cnt_width(MAX_LOSS);

    logic [TMW-1:0] timer;
    logic [LCW-1:0] loss_cnt;
    logic [LCW-1:0] loss_cnt_inc;

    assign expire       = tick && (timer == TMW'(TIMEOUT - 1));
    assign loss_cnt_inc = LCW'(sat_inc(32'(loss_cnt), 32'(MAX_LOSS)));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer    <= '0;
            loss_cnt <= '0;
            regen    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            regen <= expire;

            if (start) begin
                timer <= '0;
            end else if (tick) begin
                timer <= expire ? '0 : timer + TMW'(1);
            end

            // Only a completed lap forgives earlier losses; regeneration does not.
            if (start) begin
                loss_cnt <= loss_cnt_inc;
                if (loss_cnt_inc == LCW'(MAX_LOSS)) begin
                    fault <= 1'b1;
                end
            end else if (lap_done) begin
                loss_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Token-ring scheduler: circulates one token over N nodes, grants the holder, regenerates lost tokens.
// grant follows one cycle after PASS at a requesting node; no backpressure, done/HOLD_MAX end a tenure.
module ring_token_arbiter
    import ring_pkg::*;
#(
    parameter int N         = 4,
    parameter int HOLD_MAX  = 3,
    parameter int TIMEOUT   = 5,
    parameter int LAPS_STBL = 2,
    parameter int MAX_LOSS  = 3,
    localparam int NW       = idx_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    input  logic          loss,
    output logic [N-1:0]  grant,
    output logic [NW-1:0] pos,
    output logic          stable,
    output logic          regen,
    output logic          fault
);

    localparam int TW = cnt_width(HOLD_MAX);
    localparam int LW = cnt_width(LAPS_STBL);

    ring_state_t   state, state_nxt;
    logic [NW-1:0] pos_nxt;
    logic [TW-1:0] tenure, tenure_nxt;
    logic [LW-1:0] laps, laps_nxt, laps_inc;
    logic          stable_nxt;
    logic          timer_start;
    logic          timer_tick;
    logic          lap_done;
    logic          expire;

    assign laps_inc = LW'(sat_inc(32'(laps), 32'(LAPS_STBL)));

    ring_loss_timer #(
        .TIMEOUT  (TIMEOUT),
        .MAX_LOSS (MAX_LOSS)
    ) u_loss_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (timer_start),
        .tick     (timer_tick),
        .lap_done (lap_done),
        .expire   (expire),
        .regen    (regen),
        .fault    (fault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PASS;
            pos    <= '0;
            tenure <= '0;
            laps   <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_nxt;
            pos    <= pos_nxt;
            tenure <= tenure_nxt;
            laps   <= laps_nxt;
            stable <= stable_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        tenure_nxt  = tenure;
        laps_nxt    = laps;
        stable_nxt  = stable;
        timer_start = 1'b0;
        timer_tick  = 1'b0;
        lap_done    = 1'b0;

        unique case (state)
            PASS: begin
                if (req[pos]) begin
                    state_nxt  = HOLD;
                    tenure_nxt = '0;
                end else begin
                    state_nxt = TRANSIT;
                end
            end
            HOLD: begin
                // done and preemption in the same cycle collapse into one exit.
                if (done[pos] || (tenure == TW'(HOLD_MAX - 1))) begin
                    state_nxt = TRANSIT;
                end else begin
                    tenure_nxt = tenure + TW'(1);
                end
            end
            TRANSIT: begin
                if (loss) begin
                    state_nxt   = LOST;
                    timer_start = 1'b1;
                    stable_nxt  = 1'b0;
                    laps_nxt    = '0;
                end else begin
                    state_nxt = PASS;
                    if (pos == NW'(N - 1)) begin
                        pos_nxt  = '0;
                        lap_done = 1'b1;
                        laps_nxt = laps_inc;
                        if (laps_inc == LW'(LAPS_STBL)) begin
                            stable_nxt = 1'b1;
                        end
                    end else begin
                        pos_nxt = pos + NW'(1);
                    end
                end
            end
            LOST: begin
                timer_tick = 1'b1;
                stable_nxt = 1'b0;
                if (expire) begin
                    state_nxt = PASS;
                    pos_nxt   = '0;
                end
            end
            default: begin
                state_nxt = PASS;
            end
        endcase
    end

    always_comb begin
        grant = '0;
        if (state == HOLD) begin
            grant[pos] = 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed bench for ring_token_arbiter (N=4, HOLD_MAX=3, TIMEOUT=5, LAPS_STBL=2, MAX_LOSS=3).
module tb_ring_token_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic       loss;
    logic [3:0] grant;
    logic [1:0] pos;
    logic       stable;
    logic       regen;
    logic       fault;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ring_token_arbiter #(
        .N         (4),
        .HOLD_MAX  (3),
        .TIMEOUT   (5),
        .LAPS_STBL (2),
        .MAX_LOSS  (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .loss   (loss),
        .grant  (grant),
        .pos    (pos),
        .stable (stable),
        .regen  (regen),
        .fault  (fault)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"},  32'(grant),  32'h0);
        chk({tag, "_pos"},    32'(pos),    32'h0);
        chk({tag, "_stable"}, 32'(stable), 32'h0);
        chk({tag, "_regen"},  32'(regen),  32'h0);
        chk({tag, "_fault"},  32'(fault),  32'h0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = '0;
        loss  = 1'b0;
        step(2);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Idle circulation: pos advances every 2 cycles, stable after the 2nd wrap (cycle 16).
        step(2);  chk("idle_pos1", 32'(pos), 32'd1);
        step(2);  chk("idle_pos2", 32'(pos), 32'd2);
        step(2);  chk("idle_pos3", 32'(pos), 32'd3);
        step(2);  chk("idle_pos0", 32'(pos), 32'd0);
        chk("idle_stable_lap1", 32'(stable), 32'd0);
        step(7);  chk("idle_stable_c15", 32'(stable), 32'd0);
        chk("idle_grant", 32'(grant), 32'h0);
        step(1);  chk("idle_stable_c16", 32'(stable), 32'd1);
        chk("idle_pos_c16", 32'(pos), 32'd0);

        // Held request at node 2: three grant cycles, then one full lap before the next grant.
        req = 4'b0100;
        step(4);  chk("hold_pre_grant", 32'(grant), 32'h0);
        chk("hold_pre_pos", 32'(pos), 32'd2);
        step(1);  chk("hold_g1", 32'(grant), 32'h4);
        step(1);  chk("hold_g2", 32'(grant), 32'h4);
        step(1);  chk("hold_g3", 32'(grant), 32'h4);
        step(1);  chk("hold_preempt", 32'(grant), 32'h0);
        step(7);  chk("hold_lap_wait", 32'(grant), 32'h0);
        chk("hold_lap_pos", 32'(pos), 32'd2);
        step(1);  chk("hold_regrant", 32'(grant), 32'h4);
        req = 4'b0000;
        step(3);  chk("hold_regrant_end", 32'(grant), 32'h0);

        // Early release: done on the first grant cycle gives a single-cycle grant.
        req = 4'b0010;
        step(6);  chk("done_g1", 32'(grant), 32'h2);
        done = 4'b0010;
        req  = 4'b0000;
        step(1);  chk("done_release", 32'(grant), 32'h0);
        done = 4'b0000;
        step(1);  chk("done_next_pos", 32'(pos), 32'd2);
        chk("done_no_regrant", 32'(grant), 32'h0);
        chk("done_stable", 32'(stable), 32'd1);

        // Token loss in TRANSIT at pos 2: 5 LOST cycles, regen at node 0, 2 laps to restabilise.
        step(1);
        loss = 1'b1;
        step(1);  chk("loss_stable_drop", 32'(stable), 32'd0);
        chk("loss_pos_hold", 32'(pos), 32'd2);
        loss = 1'b0;
        step(2);  chk("loss_grant_mid", 32'(grant), 32'h0);
        step(2);  chk("loss_regen_pre", 32'(regen), 32'd0);
        chk("loss_pos_pre", 32'(pos), 32'd2);
        step(1);  chk("loss_regen", 32'(regen), 32'd1);
        chk("loss_pos_regen", 32'(pos), 32'd0);
        step(1);  chk("loss_regen_pulse", 32'(regen), 32'd0);
        step(14); chk("loss_stable_c65", 32'(stable), 32'd0);
        step(1);  chk("loss_stable_back", 32'(stable), 32'd1);
        chk("loss_fault_clear", 32'(fault), 32'd0);

        // Loss held high: ignored in PASS/LOST, taken in three consecutive TRANSITs -> fault.
        loss = 1'b1;
        step(2);  chk("fault_first_loss", 32'(stable), 32'd0);
        chk("fault_pos", 32'(pos), 32'd0);
        step(13); chk("fault_before", 32'(fault), 32'd0);
        step(1);  chk("fault_set", 32'(fault), 32'd1);
        loss = 1'b0;
        step(21); chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_stable_again", 32'(stable), 32'd1);

        // Reset mid-HOLD clears everything, including the sticky fault.
        req = 4'b0001;
        step(1);  chk("rst_hold_grant", 32'(grant), 32'h1);
        reset = 1'b1;
        req   = 4'b0000;
        step(1);  chk_reset_vals("rst_hold");
        reset = 1'b0;

        // Reset mid-LOST with the token parked at node 1.
        step(2);  chk("rst_lost_pos1", 32'(pos), 32'd1);
        loss = 1'b1;
        step(2);  chk("rst_lost_in_lost", 32'(stable), 32'd0);
        chk("rst_lost_pos", 32'(pos), 32'd1);
        step(2);
        reset = 1'b1;
        loss  = 1'b0;
        step(1);  chk_reset_vals("rst_lost");
        reset = 1'b0;
        step(2);  chk("rst_lost_resume", 32'(pos), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
